bubble_sort_seq: RTL and testbench
==================================

Name: bubble_sort_seq

Overview:
- Sequential, parametrised sorter. Accepts a DIM-element vector, sorts it in place with odd-even transposition (one compare-exchange phase per clock), and returns the ordered vector and the swap count.
- Successor to the single-pass combinational compare chain. It adds a clock, a valid/ready handshake, a runtime ascending/descending mode, early termination, and a swap counter.
- Sits between a producer and a consumer, each using valid/ready.

Parameters:
- DIM, 4, number of elements; must be at least 2.
- WIDTH, 8, element width in bits; elements are unsigned.
- SW, $clog2(DIM*(DIM-1)/2+1), swap-counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  producer has a vector.
- in_ready  out  1  block can accept a vector (high only in IDLE).
- in_data  in  DIM*WIDTH  element k at bits [k*WIDTH +: WIDTH].
- in_desc  in  1  0 = ascending, 1 = descending; sampled with in_data.
- out_valid  out  1  sorted result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  DIM*WIDTH  sorted vector, same packing as in_data. Ascending: element 0 is smallest.
- out_swaps  out  SW  total swaps performed for this vector.

Behaviour:
- Reset (async, any state): state=IDLE; element regs, out_swaps, phase counter and zero-swap flag cleared. Outputs: out_valid=0, out_data=0, out_swaps=0, in_ready=1. Reset mid-SORT or mid-DONE aborts the vector with no output.
- FSM states: IDLE, SORT, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - load elements, latch in_desc;
  - clear swap total, phase count k=0 and prev_zero;
  - go to SORT.
- SORT: each edge performs phase k (0-based):
  - pairs (i,i+1) are compared for every i with i%2 == k%2 and i+1 < DIM;
  - a swap occurs only on strict disorder: e[i] > e[i+1] in ascending, e[i] < e[i+1] in descending; equal elements never swap;
  - all pairs in a phase update simultaneously from pre-phase values;
  - the phase swap count is added to the total, and k is incremented.
- Termination: after phase k+1 completes, go to DONE if k+1 == DIM, or if k+1 >= 2 and both this phase and the previous phase had zero swaps. Otherwise stay in SORT.
- Latency: out_valid goes high P edges after the accepting edge, where P = number of phases run; P is between 2 and DIM.
- DONE:
  - out_valid=1; out_data and out_swaps stay stable until the handshake;
  - in_ready=0 and in_valid is ignored;
  - on an edge with out_ready=1, go to IDLE and drop out_valid;
  - out_data and out_swaps hold their last value in IDLE.
- No overlap: a new vector can be accepted no earlier than the edge after the result handshake.
- in_valid/in_data changes while in SORT or DONE have no effect. in_desc is only observed at the accept edge.
- Swap total equals the input inversion count (at most DIM*(DIM-1)/2), so no overflow handling is needed.
- No combinational path from in_* to out_*. in_ready and out_valid are decoded from state only.

Decomposition:
- Package bubble_sort_pkg holds:
  - state enum {IDLE, SORT, DONE};
  - helper function for the SW width;
  - mode constants ASC=0, DESC=1.
- Sub-module cmp_xchg #(WIDTH): combinational compare-exchange with a desc input. Outputs lo/hi ordered per mode plus a swapped flag. It is instantiated floor(DIM/2) times for even phases and (DIM-1)/2 times for odd phases, or muxed per pair.

Test Plan:
All scenarios use DIM=4, WIDTH=8; vectors are listed e0..e3.
- Reset check: assert rst between edges while idle, and again mid-SORT. Required: out_valid=0, in_ready=1, out_data=0, out_swaps=0 immediately; the aborted vector never appears.
- Reverse, ascending: in {4,3,2,1}, desc=0.
  - Required: phases give {3,4,1,2} → {3,1,4,2} → {1,3,2,4} → {1,2,3,4};
  - out_valid 4 edges after accept; out_data {1,2,3,4}; out_swaps=6.
- Already sorted: in {1,2,3,4}, desc=0. Required: early exit after 2 phases (out_valid 2 edges after accept); out_data unchanged; out_swaps=0.
- Descending mode: in {1,2,3,4}, desc=1. Required: out_data {4,3,2,1}; out_swaps=6; P=4.
- Duplicates, stability: in {5,5,0,5}, desc=0. Required: out_data {0,5,5,5}; out_swaps=2; P=4 (phase-limit exit).
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new data.
  - Required: out_data and out_swaps stable, in_ready=0, new data ignored;
  - after the out_ready=1 edge, return to IDLE; the next vector is accepted on the following edge.

Source files
------------

// File: rtl/bubble_sort_pkg.sv
// Shared types and helpers for the sequential odd-even transposition sorter.
package bubble_sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

    // Enough bits to hold the worst-case inversion count of a dim-element vector.
    function automatic int swapWidth(input int dim);
        return $clog2(dim * (dim - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/cmp_xchg.sv
// Combinational compare-exchange for one adjacent pair; o_lo lands at the lower index.
module cmp_xchg
    import bubble_sort_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_desc,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_swapped
);

    logic w_swap;

    // Only strict disorder swaps, so equal keys keep their relative order.
    assign w_swap    = (i_desc == DESC) ? (i_a < i_b) : (i_a > i_b);
    assign o_lo      = w_swap ? i_b : i_a;
    assign o_hi      = w_swap ? i_a : i_b;
    assign o_swapped = w_swap;

endmodule

// File: rtl/bubble_sort_seq.sv
// Sequential odd-even transposition sorter: one compare-exchange phase per clock,
// valid/ready on both sides, runtime sort direction, early exit and swap count.
module bubble_sort_seq
    import bubble_sort_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int WIDTH = 8,
    parameter int SW    = swapWidth(DIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*WIDTH-1:0] in_data,
    input  logic                 in_desc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_data,
    output logic [SW-1:0]        out_swaps
);

    localparam int PW = $clog2(DIM + 1);

    state_t               r_state;
    state_t               w_nextState;
    logic [WIDTH-1:0]     r_elem [DIM];
    logic                 r_desc;
    logic [SW-1:0]        r_swaps;
    logic [PW-1:0]        r_phase;
    logic                 r_prevZero;
    logic [DIM*WIDTH-1:0] r_outData;
    logic [SW-1:0]        r_outSwaps;

    logic [WIDTH-1:0]     w_lo [DIM-1];
    logic [WIDTH-1:0]     w_hi [DIM-1];
    logic [DIM-2:0]       w_swapped;
    logic [DIM-2:0]       w_active;
    logic [WIDTH-1:0]     w_next [DIM];
    logic [DIM*WIDTH-1:0] w_nextPacked;
    logic [SW-1:0]        w_phaseSwaps;
    logic [PW-1:0]        w_phaseInc;
    logic                 w_finish;

    // One comparator per adjacent pair; the phase parity decides which pairs act.
    for (genvar gi = 0; gi < DIM - 1; gi++) begin : g_pair
        cmp_xchg #(.WIDTH(WIDTH)) u_cmp (
            .i_a      (r_elem[gi]),
            .i_b      (r_elem[gi+1]),
            .i_desc   (r_desc),
            .o_lo     (w_lo[gi]),
            .o_hi     (w_hi[gi]),
            .o_swapped(w_swapped[gi])
        );
        assign w_active[gi] = (r_phase[0] == ((gi % 2) == 1));
    end

    always_comb begin
        w_next       = r_elem;
        w_phaseSwaps = '0;
        for (int i = 0; i < DIM - 1; i++) begin
            if (w_active[i]) begin
                w_next[i]   = w_lo[i];
                w_next[i+1] = w_hi[i];
                if (w_swapped[i]) begin
                    w_phaseSwaps = w_phaseSwaps + SW'(1);
                end
            end
        end
    end

    always_comb begin
        w_nextPacked = '0;
        for (int i = 0; i < DIM; i++) begin
            w_nextPacked[i*WIDTH +: WIDTH] = w_next[i];
        end
    end

    // Two quiet phases in a row cover both parities, so the vector is already ordered.
    assign w_phaseInc = r_phase + PW'(1);
    assign w_finish   = (w_phaseInc == PW'(DIM)) ||
                        ((w_phaseInc >= PW'(2)) && (w_phaseSwaps == '0) && r_prevZero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = SORT;
                end
            end
            SORT: begin
                if (w_finish) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Result registers only load on entry to DONE, so they hold through IDLE and the next SORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                r_elem[i] <= '0;
            end
            r_desc     <= ASC;
            r_swaps    <= '0;
            r_phase    <= '0;
            r_prevZero <= 1'b0;
            r_outData  <= '0;
            r_outSwaps <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < DIM; i++) begin
                            r_elem[i] <= in_data[i*WIDTH +: WIDTH];
                        end
                        r_desc     <= in_desc;
                        r_swaps    <= '0;
                        r_phase    <= '0;
                        r_prevZero <= 1'b0;
                    end
                end
                SORT: begin
                    r_elem     <= w_next;
                    r_swaps    <= r_swaps + w_phaseSwaps;
                    r_phase    <= w_phaseInc;
                    r_prevZero <= (w_phaseSwaps == '0);
                    if (w_finish) begin
                        r_outData  <= w_nextPacked;
                        r_outSwaps <= r_swaps + w_phaseSwaps;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data  = r_outData;
    assign out_swaps = r_outSwaps;

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Self-checking bench for bubble_sort_seq (DIM=4, WIDTH=8): directed cases, reset aborts,
// backpressure, and randomized vectors against a sort/inversion-count reference model.
module tb_bubble_sort_seq;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;
    localparam int SW    = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_desc = 1'b0;
    logic                 out_ready = 1'b0;
    logic [DIM*WIDTH-1:0] in_data = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [DIM*WIDTH-1:0] out_data;
    logic [SW-1:0]        out_swaps;

    int compared   = 0;
    int mismatched = 0;

    bubble_sort_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_desc  (in_desc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_swaps(out_swaps)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ordering via queue sort, swap total as the inversion count, and the
    // phase count by replaying transposition phases with the early-exit rule.
    function automatic void refModel(input logic [31:0] vec, input logic desc,
                                     output logic [31:0] sortedVec, output int swaps,
                                     output int phases);
        int  e[DIM];
        int  q[$];
        int  cnt;
        int  t;
        bit  prevZero;
        for (int i = 0; i < DIM; i++) begin
            e[i] = int'(vec[i*WIDTH +: WIDTH]);
            q.push_back(e[i]);
        end
        swaps = 0;
        for (int i = 0; i < DIM; i++)
            for (int j = i + 1; j < DIM; j++)
                if (desc ? (e[i] < e[j]) : (e[i] > e[j])) swaps++;
        if (desc) q.rsort(); else q.sort();
        sortedVec = '0;
        for (int i = 0; i < DIM; i++) sortedVec[i*WIDTH +: WIDTH] = 8'(q[i]);
        phases   = DIM;
        prevZero = 1'b0;
        for (int k = 0; k < DIM; k++) begin
            cnt = 0;
            for (int i = k % 2; i + 1 < DIM; i += 2) begin
                if (desc ? (e[i] < e[i+1]) : (e[i] > e[i+1])) begin
                    t = e[i]; e[i] = e[i+1]; e[i+1] = t;
                    cnt++;
                end
            end
            if (k + 1 >= 2 && cnt == 0 && prevZero) begin
                phases = k + 1;
                break;
            end
            prevZero = (cnt == 0);
        end
    endfunction

    task automatic sendVector(input logic [31:0] vec, input logic desc);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) checkOutput("acceptTimeout", in_ready, 1);
        in_valid = 1'b1;
        in_data  = vec;
        in_desc  = desc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_desc  = 1'($urandom_range(0, 1));
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("resultValid", out_valid, 1);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] vec, input logic desc,
                                 input logic [31:0] expData, input int expSwaps, input int expLat);
        int lat;
        sendVector(vec, desc);
        waitResult(lat);
        checkOutput({tag, ".lat"}, lat, expLat);
        checkOutput({tag, ".data"}, out_data, expData);
        checkOutput({tag, ".swaps"}, out_swaps, expSwaps);
        checkOutput({tag, ".inReadyDone"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, ".dropValid"}, out_valid, 0);
        checkOutput({tag, ".holdData"}, out_data, expData);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] expData;
        logic        d;
        int          expSwaps;
        int          expLat;
        int          lat;
        bit          seen;

        #1;
        checkOutput("rst.outValid", out_valid, 0);
        checkOutput("rst.inReady", in_ready, 1);
        checkOutput("rst.outData", out_data, 0);
        checkOutput("rst.outSwaps", out_swaps, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus("reverseAsc", 32'h01020304, 1'b0, 32'h04030201, 6, 4);
        applyStimulus("sortedAsc",  32'h04030201, 1'b0, 32'h04030201, 0, 2);
        applyStimulus("descMode",   32'h04030201, 1'b1, 32'h01020304, 6, 4);
        applyStimulus("dupStable",  32'h05000505, 1'b0, 32'h05050500, 2, 4);

        // Reset while idle with a previous result still on the outputs.
        #2 rst = 1'b1;
        #1;
        checkOutput("rstIdle.outData", out_data, 0);
        checkOutput("rstIdle.outSwaps", out_swaps, 0);
        checkOutput("rstIdle.inReady", in_ready, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of SORT must discard the vector entirely.
        applyStimulus("preAbort", 32'h01020304, 1'b0, 32'h04030201, 6, 4);
        sendVector(32'h01020304, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstSort.outValid", out_valid, 0);
        checkOutput("rstSort.inReady", in_ready, 1);
        checkOutput("rstSort.outData", out_data, 0);
        checkOutput("rstSort.outSwaps", out_swaps, 0);
        #2 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        checkOutput("rstSort.noOutput", seen, 0);

        // Backpressure: result must hold while new input is offered and ignored.
        sendVector(32'h01020304, 1'b0);
        waitResult(lat);
        checkOutput("bp.lat", lat, 4);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h0A0B0C0D + c;
            in_desc  = 1'b1;
            @(posedge clk); #1;
            checkOutput("bp.outValid", out_valid, 1);
            checkOutput("bp.inReady", in_ready, 0);
            checkOutput("bp.data", out_data, 32'h04030201);
            checkOutput("bp.swaps", out_swaps, 6);
        end
        in_data   = 32'h10203040;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp.releaseValid", out_valid, 0);
        checkOutput("bp.releaseReady", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp.nextAccepted", in_ready, 0);
        waitResult(lat);
        checkOutput("bp.nextLat", lat, 4);
        checkOutput("bp.nextData", out_data, 32'h40302010);
        checkOutput("bp.nextSwaps", out_swaps, 6);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized vectors with a bias toward small values so duplicates are common.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIM; i++) begin
                if ($urandom_range(0, 2) == 0)
                    v[i*WIDTH +: WIDTH] = 8'($urandom_range(0, 3));
                else
                    v[i*WIDTH +: WIDTH] = 8'($urandom_range(0, 255));
            end
            d = 1'($urandom_range(0, 1));
            refModel(v, d, expData, expSwaps, expLat);
            applyStimulus("rand", v, d, expData, expSwaps, expLat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
